// File: rtl/obi_regbank_pkg.sv
// Purpose: shared types, widths and the access-error decode for obi_regbank.
// Contents: FSM state enum, OBI field widths, response payload struct,
//           decode_err() helper used by the top-level address decode.
package obi_regbank_pkg;

    localparam int unsigned BE_W       = 4;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned MAX_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Response payload captured at accept and presented with rvalid.
    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    // Illegal access: misaligned, beyond the register window, or a write to a read-only slot.
    function automatic logic decode_err(
        input logic [MAX_ADDR_W-1:0] addr,
        input int unsigned           idx_w,
        input logic                  we,
        input logic                  ro
    );
        logic [MAX_ADDR_W-1:0] upper;
        upper = addr >> (idx_w + 32'd2);
        return (addr[1:0] != 2'b00) || (upper != '0) || (we && ro);
    endfunction

endpackage

// File: rtl/obi_regbank_if.sv
// Purpose: OBI request/response bundle between a bus master and obi_regbank.
// Signals: req/we/be/addr/wdata (master -> slave), gnt/rvalid/rdata/err (slave -> master).
interface obi_regbank_if #(
    parameter int unsigned ADDR_W = 24
);
    import obi_regbank_pkg::*;

    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata, err
    );

endinterface

// File: rtl/obi_regbank_fsm.sv
// Purpose: handshake sequencing for obi_regbank: state register, wait counter,
//          gnt/rvalid generation and response capture/hold.
// Ports: clk, rst (sync, active-high), accept_i (req && gnt this cycle),
//        rsp_i (response decoded in the accept cycle), gnt_o, rvalid_o, rsp_o.
module obi_regbank_fsm
    import obi_regbank_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic accept_i,
    input  rsp_t rsp_i,
    output logic gnt_o,
    output logic rvalid_o,
    output rsp_t rsp_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gnt_q, gnt_d;
    logic             rvalid_q, rvalid_d;
    rsp_t             rsp_q, rsp_d;
    rsp_t             pend_q, pend_d;

    // Next state; the visible response only changes when a new one is presented.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        rsp_d    = rsp_q;
        gnt_d    = 1'b1;
        rvalid_d = 1'b0;

        case (state_q)
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin  // IDLE and RESP accept identically
                state_d = IDLE;
                if (accept_i) begin
                    pend_d = rsp_i;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
        endcase

        // Zero-wait responses bypass the pending buffer.
        if (state_d == RESP) begin
            rsp_d = accept_i ? rsp_i : pend_q;
        end
        gnt_d    = (state_d != WAIT);
        rvalid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            gnt_q    <= 1'b1;
            rvalid_q <= 1'b0;
            rsp_q    <= '0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rsp_q    <= rsp_d;
            pend_q   <= pend_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign rvalid_o = rvalid_q;
    assign rsp_o    = rsp_q;

endmodule

// File: rtl/obi_regbank.sv
// Purpose: parametrised OBI register bank with RW/RO slots, byte-lane writes,
//          per-register write strobes, wait states and error responses.
// Ports: clk, rst (sync, active-high), bus (OBI slave), regs_o (RW contents,
//        RO slots 0), ro_i (status values for RO slots), wr_pulse_o (write strobes).
module obi_regbank
    import obi_regbank_pkg::*;
#(
    parameter int unsigned           NUM_REGS    = 32,
    parameter int unsigned           ADDR_W      = 24,
    parameter int unsigned           WAIT_CYCLES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_W-1:0]     RESET_VAL   = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    obi_regbank_if.slave               bus,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    input  logic [NUM_REGS*DATA_W-1:0] ro_i,
    output logic [NUM_REGS-1:0]        wr_pulse_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0]   addr_c;
    logic [IDX_W-1:0]    idx_c;
    logic                err_c;
    logic                accept_c;
    logic                wr_en_c;
    logic                gnt;
    logic                rvalid;
    rsp_t                rsp_c;
    rsp_t                rsp;

    assign addr_c   = bus.addr;
    assign idx_c    = addr_c[IDX_W+1:2];
    assign err_c    = decode_err(MAX_ADDR_W'(addr_c), IDX_W, bus.we, RO_MASK[idx_c]);
    assign accept_c = bus.req && gnt;
    assign wr_en_c  = accept_c && bus.we && !err_c;

    // Response for the access being accepted this cycle.
    always_comb begin
        rsp_c     = '0;
        rsp_c.err = err_c;
        if (!err_c && !bus.we) begin
            rsp_c.rdata = RO_MASK[idx_c] ? ro_i[idx_c*DATA_W +: DATA_W] : regs_q[idx_c];
        end
    end

    // Byte-lane update and strobe; be=0 is a legal no-op write.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (wr_en_c) begin
            for (int k = 0; k < BE_W; k++) begin
                if (bus.be[k]) begin
                    regs_d[idx_c][k*8 +: 8] = bus.wdata[k*8 +: 8];
                end
            end
            wr_pulse_d[idx_c] = (bus.be != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            wr_pulse_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    obi_regbank_fsm #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .accept_i (accept_c),
        .rsp_i    (rsp_c),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rsp_o    (rsp)
    );

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid;
    assign bus.rdata  = rsp.rdata;
    assign bus.err    = rsp.err;
    assign wr_pulse_o = wr_pulse_q;

    // RO slots have no storage visible to user logic.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs_q[g];
    end

endmodule

// File: tb/tb_obi_regbank.sv
// Purpose: self-checking bench for obi_regbank with a zero-wait and a 3-wait instance.
module tb_obi_regbank;

    localparam int          NREG = 8;
    localparam int          AW   = 24;
    localparam logic [7:0]  ROM  = 8'h48;          // slots 3 and 6 read-only
    localparam logic [31:0] RV   = 32'hA5A5_0F0F;

    typedef struct {logic we; logic [3:0] be; logic [23:0] addr; logic [31:0] wdata;} txn_t;
    typedef struct {logic [31:0] rdata; logic err; int cyc;} rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req = 1'b0, we_s = 1'b0;
    logic [3:0]  be_s = '0;
    logic [23:0] addr_s = '0;
    logic [31:0] wdata_s = '0;
    bit          sel = 1'b0;   // 0 selects dut0 (no wait), 1 selects dut3 (3 waits)

    logic [NREG*32-1:0] ro_vec = '0, regs0, regs3, o_regs;
    logic [NREG-1:0]    pulse0, pulse3, o_pulse;
    logic               o_gnt, o_rvalid, o_err;
    logic [31:0]        o_rdata;

    obi_regbank_if #(.ADDR_W(AW)) bus0 ();
    obi_regbank_if #(.ADDR_W(AW)) bus3 ();

    assign bus0.req = req & ~sel;  assign bus3.req = req & sel;
    assign bus0.we = we_s;         assign bus3.we = we_s;
    assign bus0.be = be_s;         assign bus3.be = be_s;
    assign bus0.addr = addr_s;     assign bus3.addr = addr_s;
    assign bus0.wdata = wdata_s;   assign bus3.wdata = wdata_s;

    assign o_gnt    = sel ? bus3.gnt    : bus0.gnt;
    assign o_rvalid = sel ? bus3.rvalid : bus0.rvalid;
    assign o_rdata  = sel ? bus3.rdata  : bus0.rdata;
    assign o_err    = sel ? bus3.err    : bus0.err;
    assign o_regs   = sel ? regs3       : regs0;
    assign o_pulse  = sel ? pulse3      : pulse0;

    obi_regbank #(.NUM_REGS(NREG), .ADDR_W(AW), .WAIT_CYCLES(0), .RO_MASK(ROM), .RESET_VAL(RV)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .regs_o(regs0), .ro_i(ro_vec), .wr_pulse_o(pulse0));
    obi_regbank #(.NUM_REGS(NREG), .ADDR_W(AW), .WAIT_CYCLES(3), .RO_MASK(ROM), .RESET_VAL(RV)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .regs_o(regs3), .ro_i(ro_vec), .wr_pulse_o(pulse3));

    txn_t        seq_q[$];
    rec_t        exp_q[$], obs_q[$];
    int          acc_q[$];
    logic [31:0] mreg [2][NREG];
    int          pulse_cnt[NREG], exp_pulse[NREG];
    int          hold_viol, gnt_low;
    int          n_cmp = 0, n_bad = 0;

    function automatic txn_t mk(logic w, logic [3:0] b, logic [23:0] a, logic [31:0] d);
        txn_t t;
        t.we = w; t.be = b; t.addr = a; t.wdata = d;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        int   r;
        r = $urandom_range(0, 9);
        t.we = 1'($urandom_range(0, 1));
        t.be = 4'($urandom_range(0, 15));
        t.wdata = $urandom;
        if (r == 0)      t.addr = 24'($urandom_range(0, 255));
        else if (r == 1) t.addr = 24'd1 << $urandom_range(5, 23);
        else             t.addr = 24'($urandom_range(0, NREG-1) * 4);
        return t;
    endfunction

    // Reference behaviour: address arithmetic on a plain array of words.
    task automatic model_txn(input txn_t t, output logic [31:0] rd, output logic e);
        int unsigned a;
        int          i, s;
        a = 32'(t.addr);
        i = int'(a / 4) % NREG;
        s = sel ? 1 : 0;
        e = (a % 4 != 0) || (a >= NREG * 4) || (t.we && ROM[i]);
        rd = '0;
        if (!e) begin
            if (t.we) begin
                for (int k = 0; k < 4; k++)
                    if (t.be[k]) mreg[s][i][k*8 +: 8] = t.wdata[k*8 +: 8];
                if (t.be != 4'h0) exp_pulse[i]++;
            end else begin
                rd = ROM[i] ? ro_vec[i*32 +: 32] : mreg[s][i];
            end
        end
    endtask

    task automatic drive(input txn_t t);
        we_s = t.we; be_s = t.be; addr_s = t.addr; wdata_s = t.wdata;
    endtask

    function automatic logic [NREG*32-1:0] exp_regs();
        logic [NREG*32-1:0] v;
        for (int i = 0; i < NREG; i++) v[i*32 +: 32] = ROM[i] ? 32'h0 : mreg[sel ? 1 : 0][i];
        return v;
    endfunction

    // Plays seq_q with req held, logging expected and observed responses per cycle.
    task automatic run_seq();
        int          cyc, idx, last_exp, limit, wc;
        bit          acc_pend;
        logic [31:0] last_rd, rd;
        logic        last_err, e;
        rec_t        r;
        exp_q.delete(); obs_q.delete(); acc_q.delete();
        hold_viol = 0; gnt_low = 0;
        for (int i = 0; i < NREG; i++) begin pulse_cnt[i] = 0; exp_pulse[i] = 0; end
        cyc = 0; idx = 0; acc_pend = 0; last_exp = 0;
        wc = sel ? 3 : 0;
        limit = 40 + 10 * seq_q.size();
        @(negedge clk);
        last_rd = o_rdata; last_err = o_err;
        if (seq_q.size() > 0) begin drive(seq_q[0]); req = 1'b1; end
        while (cyc < limit) begin
            if (o_rvalid === 1'b1) begin
                r.rdata = o_rdata; r.err = o_err; r.cyc = cyc;
                obs_q.push_back(r);
                last_rd = o_rdata; last_err = o_err;
            end else if (o_rdata !== last_rd || o_err !== last_err) begin
                hold_viol++;
            end
            if (o_gnt !== 1'b1) gnt_low++;
            for (int i = 0; i < NREG; i++) pulse_cnt[i] += int'(o_pulse[i]);
            if (acc_pend) begin
                acc_pend = 0; idx++;
                if (idx < seq_q.size()) drive(seq_q[idx]); else req = 1'b0;
            end
            if (req && o_gnt === 1'b1) begin
                model_txn(seq_q[idx], rd, e);
                r.rdata = rd; r.err = e; r.cyc = cyc + wc + 1;
                exp_q.push_back(r); acc_q.push_back(cyc);
                last_exp = r.cyc; acc_pend = 1;
            end
            if (idx >= seq_q.size() && cyc >= last_exp + 2) break;
            @(negedge clk);
            cyc++;
        end
        req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < NREG; i++) begin mreg[0][i] = RV; mreg[1][i] = RV; end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            n_cmp++; if (o_gnt !== 1'b1) begin n_bad++; $display("FAIL reset_gnt dut%0d: got %b want 1", s, o_gnt); end
            n_cmp++; if (o_rvalid !== 1'b0) begin n_bad++; $display("FAIL reset_rvalid dut%0d: got %b want 0", s, o_rvalid); end
            n_cmp++; if (o_rdata !== 32'h0 || o_err !== 1'b0) begin n_bad++; $display("FAIL reset_rsp dut%0d: got %h/%b want 0/0", s, o_rdata, o_err); end
            n_cmp++; if (o_pulse !== '0) begin n_bad++; $display("FAIL reset_pulse dut%0d: got %b want 0", s, o_pulse); end
            n_cmp++; if (o_regs !== exp_regs()) begin n_bad++; $display("FAIL reset_regs dut%0d: got %h want %h", s, o_regs, exp_regs()); end
        end
        sel = 1'b0;
    endtask

    task automatic test_write_read();
        sel = 1'b0;
        seq_q = '{mk(1'b1, 4'hF, 24'h04, 32'hDEADBEEF), mk(1'b0, 4'h0, 24'h04, 32'h0)};
        run_seq();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL wr_rd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].cyc !== exp_q[i].cyc) begin
                n_bad++; $display("FAIL wr_rd_rsp%0d: got %h/%b@%0d want %h/%b@%0d", i,
                    obs_q[i].rdata, obs_q[i].err, obs_q[i].cyc, exp_q[i].rdata, exp_q[i].err, exp_q[i].cyc);
            end
        end
        if (obs_q.size() == 2) begin
            n_cmp++; if (obs_q[1].rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wr_rd_value: got %h want deadbeef", obs_q[1].rdata); end
        end
        n_cmp++; if (pulse_cnt[1] !== 1) begin n_bad++; $display("FAIL wr_rd_pulse1: got %0d want 1", pulse_cnt[1]); end
        n_cmp++; if (o_regs !== exp_regs()) begin n_bad++; $display("FAIL wr_rd_regs: got %h want %h", o_regs, exp_regs()); end
    endtask

    task automatic test_byte_lanes();
        sel = 1'b0;
        seq_q = '{mk(1'b1, 4'hF, 24'h08, 32'hAAAAAAAA), mk(1'b1, 4'b0101, 24'h08, 32'h11223344),
                  mk(1'b0, 4'hF, 24'h08, 32'h0)};
        run_seq();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bytes_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].cyc !== exp_q[i].cyc) begin
                n_bad++; $display("FAIL bytes_rsp%0d: got %h/%b@%0d want %h/%b@%0d", i,
                    obs_q[i].rdata, obs_q[i].err, obs_q[i].cyc, exp_q[i].rdata, exp_q[i].err, exp_q[i].cyc);
            end
        end
        if (obs_q.size() == 3) begin
            n_cmp++; if (obs_q[2].rdata !== 32'hAA22AA44) begin n_bad++; $display("FAIL bytes_value: got %h want aa22aa44", obs_q[2].rdata); end
        end
        n_cmp++; if (pulse_cnt[2] !== 2) begin n_bad++; $display("FAIL bytes_pulse2: got %0d want 2", pulse_cnt[2]); end
    endtask

    task automatic test_errors();
        sel = 1'b0;
        ro_vec[3*32 +: 32] = 32'h0000CAFE;
        seq_q = '{mk(1'b0, 4'hF, 24'h02, 32'h0), mk(1'b0, 4'hF, 24'(NREG*4), 32'h0),
                  mk(1'b1, 4'hF, 24'h0C, 32'h12345678), mk(1'b1, 4'h0, 24'h10, 32'hFFFFFFFF),
                  mk(1'b0, 4'h0, 24'h10, 32'h0), mk(1'b0, 4'hF, 24'h0C, 32'h0),
                  mk(1'b1, 4'hF, 24'h01, 32'h87654321)};
        run_seq();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL err_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].cyc !== exp_q[i].cyc) begin
                n_bad++; $display("FAIL err_rsp%0d: got %h/%b@%0d want %h/%b@%0d", i,
                    obs_q[i].rdata, obs_q[i].err, obs_q[i].cyc, exp_q[i].rdata, exp_q[i].err, exp_q[i].cyc);
            end
        end
        if (obs_q.size() == 7) begin
            n_cmp++; if (obs_q[0].err !== 1'b1 || obs_q[1].err !== 1'b1 || obs_q[2].err !== 1'b1 || obs_q[6].err !== 1'b1)
                begin n_bad++; $display("FAIL err_flags: got %b%b%b%b want 1111", obs_q[0].err, obs_q[1].err, obs_q[2].err, obs_q[6].err); end
            n_cmp++; if (obs_q[4].rdata !== RV) begin n_bad++; $display("FAIL err_be0_noop: got %h want %h", obs_q[4].rdata, RV); end
            n_cmp++; if (obs_q[5].rdata !== 32'h0000CAFE) begin n_bad++; $display("FAIL err_ro_read: got %h want 0000cafe", obs_q[5].rdata); end
        end
        for (int i = 0; i < NREG; i++) begin
            n_cmp++; if (pulse_cnt[i] !== 0) begin n_bad++; $display("FAIL err_pulse%0d: got %0d want 0", i, pulse_cnt[i]); end
        end
        n_cmp++; if (o_regs !== exp_regs()) begin n_bad++; $display("FAIL err_regs: got %h want %h", o_regs, exp_regs()); end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        for (int i = 0; i < NREG; i++) ro_vec[i*32 +: 32] = $urandom;
        seq_q.delete();
        for (int i = 0; i < 60; i++) seq_q.push_back(rand_txn());
        run_seq();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].cyc !== exp_q[i].cyc) begin
                n_bad++; $display("FAIL b2b_rsp%0d: got %h/%b@%0d want %h/%b@%0d", i,
                    obs_q[i].rdata, obs_q[i].err, obs_q[i].cyc, exp_q[i].rdata, exp_q[i].err, exp_q[i].cyc);
            end
        end
        n_cmp++; if (acc_q.size() != 60 || acc_q[$] - acc_q[0] != 59) begin n_bad++; $display("FAIL b2b_throughput: got %0d accepts spanning %0d want 60 spanning 59", acc_q.size(), (acc_q.size() > 0) ? acc_q[$] - acc_q[0] : -1); end
        for (int i = 0; i < NREG; i++) begin
            n_cmp++; if (pulse_cnt[i] !== exp_pulse[i]) begin n_bad++; $display("FAIL b2b_pulse%0d: got %0d want %0d", i, pulse_cnt[i], exp_pulse[i]); end
        end
        n_cmp++; if (hold_viol !== 0) begin n_bad++; $display("FAIL b2b_hold: got %0d changes want 0", hold_viol); end
        n_cmp++; if (o_regs !== exp_regs()) begin n_bad++; $display("FAIL b2b_regs: got %h want %h", o_regs, exp_regs()); end
    endtask

    task automatic test_wait_states();
        sel = 1'b1;
        seq_q = '{mk(1'b1, 4'hF, 24'h14, 32'h0BADF00D), mk(1'b0, 4'h0, 24'h14, 32'h0), mk(1'b0, 4'h0, 24'h0C, 32'h0)};
        for (int i = 0; i < 12; i++) seq_q.push_back(rand_txn());
        run_seq();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL wait_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i].rdata !== exp_q[i].rdata || obs_q[i].err !== exp_q[i].err || obs_q[i].cyc !== exp_q[i].cyc) begin
                n_bad++; $display("FAIL wait_rsp%0d: got %h/%b@%0d want %h/%b@%0d", i,
                    obs_q[i].rdata, obs_q[i].err, obs_q[i].cyc, exp_q[i].rdata, exp_q[i].err, exp_q[i].cyc);
            end
        end
        for (int i = 1; i < acc_q.size(); i++) begin
            n_cmp++; if (acc_q[i] - acc_q[i-1] !== 4) begin n_bad++; $display("FAIL wait_spacing%0d: got %0d want 4", i, acc_q[i] - acc_q[i-1]); end
        end
        n_cmp++; if (gnt_low !== 3 * seq_q.size()) begin n_bad++; $display("FAIL wait_gnt_low: got %0d want %0d", gnt_low, 3 * seq_q.size()); end
        n_cmp++; if (hold_viol !== 0) begin n_bad++; $display("FAIL wait_hold: got %0d changes want 0", hold_viol); end
        for (int i = 0; i < NREG; i++) begin
            n_cmp++; if (pulse_cnt[i] !== exp_pulse[i]) begin n_bad++; $display("FAIL wait_pulse%0d: got %0d want %0d", i, pulse_cnt[i], exp_pulse[i]); end
        end
        n_cmp++; if (o_regs !== exp_regs()) begin n_bad++; $display("FAIL wait_regs: got %h want %h", o_regs, exp_regs()); end
    endtask

    task automatic test_reset_mid();
        int rv_seen;
        sel = 1'b1;
        seq_q = '{mk(1'b1, 4'hF, 24'h14, 32'h12345678)};
        run_seq();
        n_cmp++; if (o_regs[5*32 +: 32] !== 32'h12345678) begin n_bad++; $display("FAIL mid_prewrite: got %h want 12345678", o_regs[5*32 +: 32]); end
        @(negedge clk);
        drive(mk(1'b0, 4'hF, 24'h14, 32'h0)); req = 1'b1;
        n_cmp++; if (o_gnt !== 1'b1) begin n_bad++; $display("FAIL mid_gnt_idle: got %b want 1", o_gnt); end
        @(negedge clk);
        req = 1'b0;
        n_cmp++; if (o_gnt !== 1'b0) begin n_bad++; $display("FAIL mid_gnt_wait: got %b want 0", o_gnt); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) begin mreg[0][i] = RV; mreg[1][i] = RV; end
        n_cmp++; if (o_gnt !== 1'b1) begin n_bad++; $display("FAIL mid_gnt_release: got %b want 1", o_gnt); end
        n_cmp++; if (o_regs !== exp_regs()) begin n_bad++; $display("FAIL mid_regs: got %h want %h", o_regs, exp_regs()); end
        rv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            rv_seen += int'(o_rvalid === 1'b1);
            @(negedge clk);
        end
        n_cmp++; if (rv_seen !== 0) begin n_bad++; $display("FAIL mid_dropped: got %0d rvalid want 0", rv_seen); end
        n_cmp++; if (o_gnt !== 1'b1 || o_rdata !== 32'h0) begin n_bad++; $display("FAIL mid_after: got gnt %b rdata %h want 1/0", o_gnt, o_rdata); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_errors();
        test_back_to_back();
        test_wait_states();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
